// File: rtl/moore_1010_pkg.sv
// Shared types and constants for the moore_1010 serial "1010" detector.
package moore_1010_pkg;

  localparam int unsigned StateWidth = 3;
  localparam int unsigned CountWidth = 8;
  localparam logic [3:0]  Pattern    = 4'b1010;

  // Encodings are observed externally through the state register.
  typedef enum logic [StateWidth-1:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_e;

endpackage

// File: rtl/moore_1010_sat_counter.sv
// Saturating detection counter for moore_1010; clears on synchronous active-low reset.
module moore_1010_sat_counter
  import moore_1010_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inc_i,
  output logic [CountWidth-1:0] count_o
);

  logic [CountWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/moore_1010.sv
// Moore detector for serial pattern 1010; out is decoded from state only.
// Define MOORE_1010_COUNT_EN to add the saturating 8-bit detection counter output.
module moore_1010
  import moore_1010_pkg::*;
#(
  parameter int unsigned OVERLAP = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in,
  output logic                  out
`ifdef MOORE_1010_COUNT_EN
  ,
  output logic [CountWidth-1:0] count
`endif
);

  state_e y, y_d;

  // Each progress state advances when in matches the next pattern bit.
  always_comb begin
    y_d = S0;
    case (y)
      S0:      y_d = (in == Pattern[3]) ? S1 : S0;
      S1:      y_d = (in == Pattern[2]) ? S2 : S1;
      S2:      y_d = (in == Pattern[1]) ? S3 : S0;
      S3:      y_d = (in == Pattern[0]) ? S4 : S1;
      S4:      y_d = in ? ((OVERLAP != 0) ? S3 : S1) : S0;
      default: y_d = S0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      y <= S0;
    end else begin
      y <= y_d;
    end
  end

  // Full compare keeps out low in the unused codes.
  always_comb begin
    out = 1'b0;
    if (y == S4) begin
      out = 1'b1;
    end
  end

`ifdef MOORE_1010_COUNT_EN
  logic det_inc;
  assign det_inc = (y_d == S4);

  moore_1010_sat_counter u_sat_counter (
    .clock   (clock),
    .reset   (reset),
    .inc_i   (det_inc),
    .count_o (count)
  );
`endif

endmodule

// File: tb/tb_moore_1010.sv
// Scoreboard bench for moore_1010: overlapping and non-overlapping instances side by side.
module tb_moore_1010;
  import moore_1010_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic din   = 1'b0;
  logic out1, out0;
`ifdef MOORE_1010_COUNT_EN
  logic [7:0] count1, count0;
`endif

  always #5 clock = ~clock;

  moore_1010 #(.OVERLAP(1)) dut (
    .clock (clock),
    .reset (reset),
    .in    (din),
    .out   (out1)
`ifdef MOORE_1010_COUNT_EN
    ,
    .count (count1)
`endif
  );

  moore_1010 #(.OVERLAP(0)) dut_nov (
    .clock (clock),
    .reset (reset),
    .in    (din),
    .out   (out0)
`ifdef MOORE_1010_COUNT_EN
    ,
    .count (count0)
`endif
  );

  typedef struct {
    logic [2:0] y1;
    logic [2:0] y0;
    logic [7:0] c1;
    logic [7:0] c0;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   c1       = 0;
  int   c0       = 0;

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: one expected entry per clock edge, checked just after the edge.
  always @(posedge clock) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("y_ovl",   {5'b0, dut.y},     {5'b0, e.y1});
      chk("out_ovl", {7'b0, out1},      {7'b0, (e.y1 == 3'b100)});
      chk("y_nov",   {5'b0, dut_nov.y}, {5'b0, e.y0});
      chk("out_nov", {7'b0, out0},      {7'b0, (e.y0 == 3'b100)});
`ifdef MOORE_1010_COUNT_EN
      chk("count_ovl", count1, e.c1);
      chk("count_nov", count0, e.c0);
`endif
    end
  end

  // Drive one bit and queue the states expected after the coming edge.
  task automatic step(input logic r, input logic b, input logic [2:0] e1, input logic [2:0] e0);
    exp_t e;
    @(negedge clock);
    reset = r;
    din   = b;
    if (!r) begin
      c1 = 0;
      c0 = 0;
    end else begin
      if (e1 == 3'b100 && c1 < 255) c1++;
      if (e0 == 3'b100 && c0 < 255) c0++;
    end
    e.y1 = e1;
    e.y0 = e0;
    e.c1 = 8'(c1);
    e.c0 = 8'(c0);
    sb.push_back(e);
  endtask

  initial begin
    // Reset held two edges with in toggling
    step(1'b0, 1'b1, 3'd0, 3'd0);
    step(1'b0, 1'b0, 3'd0, 3'd0);
    // Single match 0,1,0,1,0 then idle
    step(1'b1, 1'b0, 3'd0, 3'd0);
    step(1'b1, 1'b1, 3'd1, 3'd1);
    step(1'b1, 1'b0, 3'd2, 3'd2);
    step(1'b1, 1'b1, 3'd3, 3'd3);
    step(1'b1, 1'b0, 3'd4, 3'd4);
    step(1'b1, 1'b0, 3'd0, 3'd0);
    // 1,0,1,0,1,0: two pulses with overlap, one without
    step(1'b1, 1'b1, 3'd1, 3'd1);
    step(1'b1, 1'b0, 3'd2, 3'd2);
    step(1'b1, 1'b1, 3'd3, 3'd3);
    step(1'b1, 1'b0, 3'd4, 3'd4);
    step(1'b1, 1'b1, 3'd3, 3'd1);
    step(1'b1, 1'b0, 3'd4, 3'd2);
    step(1'b1, 1'b0, 3'd0, 3'd0);
    // Near misses 1,1,0,1,1,0,0
    step(1'b1, 1'b1, 3'd1, 3'd1);
    step(1'b1, 1'b1, 3'd1, 3'd1);
    step(1'b1, 1'b0, 3'd2, 3'd2);
    step(1'b1, 1'b1, 3'd3, 3'd3);
    step(1'b1, 1'b1, 3'd1, 3'd1);
    step(1'b1, 1'b0, 3'd2, 3'd2);
    step(1'b1, 1'b0, 3'd0, 3'd0);
    // Reset in S3 with in=0 must beat the S4 transition
    step(1'b1, 1'b1, 3'd1, 3'd1);
    step(1'b1, 1'b0, 3'd2, 3'd2);
    step(1'b1, 1'b1, 3'd3, 3'd3);
    step(1'b0, 1'b0, 3'd0, 3'd0);
    step(1'b1, 1'b0, 3'd0, 3'd0);
    // First edge after reset counts as the first pattern bit
    step(1'b0, 1'b0, 3'd0, 3'd0);
    step(1'b1, 1'b1, 3'd1, 3'd1);
    step(1'b1, 1'b0, 3'd2, 3'd2);
    step(1'b1, 1'b1, 3'd3, 3'd3);
    step(1'b1, 1'b0, 3'd4, 3'd4);
    step(1'b1, 1'b0, 3'd0, 3'd0);
    // 261 "10" pairs: 260 overlapping matches (saturates), 130 non-overlapping
    step(1'b0, 1'b0, 3'd0, 3'd0);
    for (int k = 1; k <= 261; k++) begin
      step(1'b1, 1'b1, (k == 1) ? 3'd1 : 3'd3, (k % 2 == 1) ? 3'd1 : 3'd3);
      step(1'b1, 1'b0, (k == 1) ? 3'd2 : 3'd4, (k % 2 == 1) ? 3'd2 : 3'd4);
    end
    step(1'b1, 1'b0, 3'd0, 3'd0);
    // Reset clears the counter
    step(1'b0, 1'b1, 3'd0, 3'd0);
    step(1'b1, 1'b0, 3'd0, 3'd0);
    repeat (3) @(posedge clock);
    #2;
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
